// File: rtl/pll_seq_ctrl.sv
// Sequencer and lock supervisor for a Gowin rPLL.
// Drives the PLL reset, qualifies the (asynchronous) LOCK signal, retries on
// lock timeout, releases the downstream reset once lock is stable, and
// serialises run-time PSDA/DUTYDA updates through a req/ack handshake.
// Everything runs on the free-running PLL reference clock.
module pll_seq_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int LOCK_STABLE   = 64,   // must be >= 2
  parameter int MAX_RETRY     = 3,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic       clkin,
  input  logic       reset_n,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [3:0] psda,
  output logic [3:0] dutyda,
  input  logic       cfg_req,
  input  logic [3:0] cfg_psda,
  input  logic [3:0] cfg_dutyda,
  output logic       cfg_ack,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       fault,
  output logic [1:0] retry_cnt
);

  // Shared counter must cover the longest interval of any state.
  localparam int MAX_A   = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
  localparam int MAX_B   = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  // The WAIT cycle that first observes lock_s=1 counts as the first of the
  // LOCK_STABLE consecutive high samples, so STABLE itself needs one fewer.
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 2);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_WAIT,
    ST_STABLE,
    ST_RUN,
    ST_SETTLE,
    ST_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic [3:0]       psda_q, psda_d;
  logic [3:0]       dutyda_q, dutyda_d;
  logic             cfg_ack_q, cfg_ack_d;
  logic             pll_reset_q, pll_reset_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             locked_q, locked_d;
  logic             fault_q, fault_d;
  logic             lock_meta_q, lock_s_q;

  // Two-flop synchroniser for the asynchronous PLL LOCK input.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  // Next-state, counter, retry, config latch and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    retry_d   = retry_q;
    psda_d    = psda_q;
    dutyda_d  = dutyda_q;
    cfg_ack_d = 1'b0;

    unique case (state_q)
      ST_HOLD: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Lock takes priority over a timeout landing in the same cycle.
        if (lock_s_q) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = ST_FAULT;
          end else begin
            retry_d = retry_q + 2'd1;
            state_d = ST_HOLD;
          end
        end
      end

      ST_STABLE: begin
        if (!lock_s_q) begin
          state_d = ST_WAIT;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        cnt_d = cnt_q;
        if (!lock_s_q) begin
          state_d = ST_HOLD;
        end else if (cfg_req && !cfg_ack_q) begin
          // cfg_ack_q high means the requester may still be holding the
          // request it was just acknowledged for; ignore it for that cycle.
          psda_d   = cfg_psda;
          dutyda_d = cfg_dutyda;
          state_d  = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (!lock_s_q) begin
          // Lock loss aborts the update silently; new values stay applied.
          state_d = ST_HOLD;
        end else if (cnt_q == SETTLE_LAST) begin
          cfg_ack_d = 1'b1;
          state_d   = ST_RUN;
        end
      end

      ST_FAULT: begin
        cnt_d = cnt_q;
      end

      default: begin
        state_d = ST_HOLD;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    // Retries count within one lock sequence; reaching RUN ends it.
    if (state_d == ST_RUN) begin
      retry_d = 2'd0;
    end

    // Outputs are decoded from the next state so they are registered and
    // change in the same cycle the state does.
    pll_reset_d = (state_d == ST_HOLD) || (state_d == ST_FAULT);
    locked_d    = (state_d == ST_RUN) || (state_d == ST_SETTLE);
    sys_rst_n_d = locked_d;
    fault_d     = fault_q || (state_d == ST_FAULT);
  end

  // State and output registers.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      retry_q     <= 2'd0;
      psda_q      <= 4'b0000;
      dutyda_q    <= 4'b1000;
      cfg_ack_q   <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      psda_q      <= psda_d;
      dutyda_q    <= dutyda_d;
      cfg_ack_q   <= cfg_ack_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      locked_q    <= locked_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign psda      = psda_q;
  assign dutyda    = dutyda_q;
  assign cfg_ack   = cfg_ack_q;
  assign sys_rst_n = sys_rst_n_q;
  assign locked    = locked_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Directed testbench for pll_seq_ctrl: lock sequencing, retry/fault,
// lock glitch, config handshake, lock loss during settle, async reset.
module tb_pll_seq_ctrl;

  logic       clkin;
  logic       reset_n;
  logic       pll_lock;
  logic       pll_reset;
  logic [3:0] psda;
  logic [3:0] dutyda;
  logic       cfg_req;
  logic [3:0] cfg_psda;
  logic [3:0] cfg_dutyda;
  logic       cfg_ack;
  logic       sys_rst_n;
  logic       locked;
  logic       fault;
  logic [1:0] retry_cnt;

  int errors = 0;
  int checks = 0;

  pll_seq_ctrl dut (
    .clkin      (clkin),
    .reset_n    (reset_n),
    .pll_lock   (pll_lock),
    .pll_reset  (pll_reset),
    .psda       (psda),
    .dutyda     (dutyda),
    .cfg_req    (cfg_req),
    .cfg_psda   (cfg_psda),
    .cfg_dutyda (cfg_dutyda),
    .cfg_ack    (cfg_ack),
    .sys_rst_n  (sys_rst_n),
    .locked     (locked),
    .fault      (fault),
    .retry_cnt  (retry_cnt)
  );

  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock edge, then sample/drive 1 time unit after it.
  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    pll_lock   = 1'b0;
    cfg_req    = 1'b0;
    cfg_psda   = 4'b0000;
    cfg_dutyda = 4'b0000;
    #23;
    checks++;
    if (pll_reset !== 1'b1 || sys_rst_n !== 1'b0 || locked !== 1'b0 ||
        fault !== 1'b0 || cfg_ack !== 1'b0 || retry_cnt !== 2'd0 ||
        psda !== 4'b0000 || dutyda !== 4'b1000) begin
      errors++;
      $display("FAIL reset_values: got rst=%b srst_n=%b lk=%b flt=%b ack=%b rty=%0d psda=%b duty=%b, need 1 0 0 0 0 0 0000 1000",
               pll_reset, sys_rst_n, locked, fault, cfg_ack, retry_cnt, psda, dutyda);
    end
    $display("reset: pll_reset=%b sys_rst_n=%b dutyda=%b", pll_reset, sys_rst_n, dutyda);
  endtask

  // Release reset_n between edges and measure the first HOLD pulse.
  task automatic release_and_hold(input string tag);
    int n;
    @(negedge clkin);
    reset_n = 1'b1;
    n = 0;
    while (pll_reset !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL %s_hold_len: got %0d cycles, need 16", tag, n);
    end
    $display("%s: pll_reset high for %0d cycles", tag, n);
  endtask

  task automatic test_lock_good();
    int n;
    release_and_hold("lock_good");
    repeat (100) tick();
    pll_lock = 1'b1;
    n = 0;
    while (locked !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n != 66) begin
      errors++;
      $display("FAIL lock_good_latency: locked after %0d cycles, need 66", n);
    end
    checks++;
    if (sys_rst_n !== 1'b1 || fault !== 1'b0 || retry_cnt !== 2'd0 || pll_reset !== 1'b0) begin
      errors++;
      $display("FAIL lock_good_outputs: srst_n=%b flt=%b rty=%0d rst=%b, need 1 0 0 0",
               sys_rst_n, fault, retry_cnt, pll_reset);
    end
    $display("lock_good: locked after %0d cycles", n);
  endtask

  task automatic test_cfg_update();
    int n;
    bit srst_dropped;
    cfg_psda   = 4'b0101;
    cfg_dutyda = 4'b0110;
    cfg_req    = 1'b1;
    tick();
    checks++;
    if (psda !== 4'b0101 || dutyda !== 4'b0110 || cfg_ack !== 1'b0) begin
      errors++;
      $display("FAIL cfg_latch: psda=%b duty=%b ack=%b, need 0101 0110 0", psda, dutyda, cfg_ack);
    end
    n = 0;
    srst_dropped = 1'b0;
    while (cfg_ack !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (sys_rst_n !== 1'b1) srst_dropped = 1'b1;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL cfg_ack_latency: ack %0d cycles after update, need 8", n);
    end
    checks++;
    if (srst_dropped) begin
      errors++;
      $display("FAIL cfg_sys_rst: sys_rst_n went low during settle, need 1");
    end
    cfg_req = 1'b0;
    tick();
    checks++;
    if (cfg_ack !== 1'b0) begin
      errors++;
      $display("FAIL cfg_ack_pulse: ack=%b one cycle later, need 0", cfg_ack);
    end
    repeat (3) tick();
    checks++;
    if (cfg_ack !== 1'b0 || psda !== 4'b0101 || locked !== 1'b1) begin
      errors++;
      $display("FAIL cfg_idle: ack=%b psda=%b lk=%b, need 0 0101 1", cfg_ack, psda, locked);
    end
    $display("cfg txn: psda=%b dutyda=%b acked after %0d cycles", psda, dutyda, n);
  endtask

  task automatic test_back_to_back();
    int n;
    cfg_psda   = 4'b1100;
    cfg_dutyda = 4'b0011;
    cfg_req    = 1'b1;
    tick();
    n = 0;
    while (cfg_ack !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 8 || psda !== 4'b1100) begin
      errors++;
      $display("FAIL b2b_first: ack after %0d psda=%b, need 8 1100", n, psda);
    end
    // Request stays high past the ack cycle with new data.
    cfg_psda   = 4'b1010;
    cfg_dutyda = 4'b0001;
    tick();
    checks++;
    if (cfg_ack !== 1'b0 || psda !== 4'b1100) begin
      errors++;
      $display("FAIL b2b_ack_cycle_ignored: ack=%b psda=%b, need 0 1100", cfg_ack, psda);
    end
    tick();
    checks++;
    if (psda !== 4'b1010 || dutyda !== 4'b0001) begin
      errors++;
      $display("FAIL b2b_second_latch: psda=%b duty=%b, need 1010 0001", psda, dutyda);
    end
    n = 0;
    while (cfg_ack !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL b2b_second_ack: ack after %0d cycles, need 8", n);
    end
    cfg_req = 1'b0;
    tick();
    $display("cfg b2b txn: psda=%b dutyda=%b", psda, dutyda);
  endtask

  task automatic test_settle_lock_loss();
    int n;
    bit ack_seen;
    cfg_psda   = 4'b0101;
    cfg_dutyda = 4'b0110;
    cfg_req    = 1'b1;
    tick();
    repeat (3) tick();
    pll_lock = 1'b0;
    ack_seen = 1'b0;
    tick();
    tick();
    checks++;
    if (sys_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL settle_loss_early: sys_rst_n=%b 2 cycles after drop, need 1", sys_rst_n);
    end
    tick();
    checks++;
    if (sys_rst_n !== 1'b0 || pll_reset !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL settle_loss_react: srst_n=%b rst=%b lk=%b, need 0 1 0", sys_rst_n, pll_reset, locked);
    end
    n = 0;
    while (pll_reset !== 1'b0 && n < 100) begin
      if (cfg_ack === 1'b1) ack_seen = 1'b1;
      checks++;
      if (psda !== 4'b0101) begin
        errors++;
        $display("FAIL settle_loss_psda: psda=%b in HOLD, need 0101", psda);
      end
      tick();
      n++;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL settle_loss_hold_len: got %0d cycles, need 16", n);
    end
    checks++;
    if (ack_seen || cfg_ack !== 1'b0) begin
      errors++;
      $display("FAIL settle_loss_no_ack: ack seen, need none");
    end
    // Request is still pending; it must be serviced once RUN is reached.
    pll_lock = 1'b1;
    n = 0;
    while (locked !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n != 66) begin
      errors++;
      $display("FAIL settle_loss_relock: locked after %0d cycles, need 66", n);
    end
    while (cfg_ack !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n != 75 || psda !== 4'b0101 || dutyda !== 4'b0110) begin
      errors++;
      $display("FAIL settle_loss_pending: ack at %0d psda=%b duty=%b, need 75 0101 0110", n, psda, dutyda);
    end
    cfg_req = 1'b0;
    tick();
    $display("settle lock loss: relocked, pending cfg acked at cycle %0d", n);
  endtask

  task automatic test_async_reset();
    repeat (2) tick();
    @(posedge clkin);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (sys_rst_n !== 1'b0 || pll_reset !== 1'b1 || dutyda !== 4'b1000 ||
        psda !== 4'b0000 || locked !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: srst_n=%b rst=%b duty=%b psda=%b lk=%b, need 0 1 1000 0000 0",
               sys_rst_n, pll_reset, dutyda, psda, locked);
    end
    $display("async reset: sys_rst_n=%b pll_reset=%b dutyda=%b", sys_rst_n, pll_reset, dutyda);
    #20;
  endtask

  task automatic test_glitch();
    int n;
    bit rst_seen;
    pll_lock = 1'b0;
    release_and_hold("glitch");
    repeat (10) tick();
    pll_lock = 1'b1;
    repeat (32) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    n = 0;
    rst_seen = 1'b0;
    while (locked !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (pll_reset !== 1'b0) rst_seen = 1'b1;
    end
    checks++;
    if (n != 66) begin
      errors++;
      $display("FAIL glitch_relock: locked %0d cycles after relock, need 66", n);
    end
    checks++;
    if (rst_seen || retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL glitch_no_reseq: pll_reset pulsed=%b rty=%0d, need 0 0", rst_seen, retry_cnt);
    end
    $display("glitch: locked %0d cycles after relock", n);
  endtask

  task automatic test_fault();
    int n;
    reset_n  = 1'b0;
    pll_lock = 1'b0;
    #20;
    release_and_hold("fault");
    for (int r = 1; r <= 4; r++) begin
      n = 0;
      while (pll_reset !== 1'b1 && n < 5000) begin
        tick();
        n++;
      end
      checks++;
      if (n != 4096) begin
        errors++;
        $display("FAIL timeout_len_%0d: got %0d cycles, need 4096", r, n);
      end
      if (r <= 3) begin
        checks++;
        if (retry_cnt !== 2'(r) || fault !== 1'b0) begin
          errors++;
          $display("FAIL retry_%0d: rty=%0d flt=%b, need %0d 0", r, retry_cnt, fault, r);
        end
        n = 0;
        while (pll_reset !== 1'b0 && n < 100) begin
          tick();
          n++;
        end
        checks++;
        if (n != 16) begin
          errors++;
          $display("FAIL retry_hold_%0d: got %0d cycles, need 16", r, n);
        end
        $display("retry %0d: hold pulse %0d cycles", r, n);
      end
    end
    checks++;
    if (fault !== 1'b1 || pll_reset !== 1'b1 || retry_cnt !== 2'd3 || sys_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL fault_entry: flt=%b rst=%b rty=%0d srst_n=%b, need 1 1 3 0",
               fault, pll_reset, retry_cnt, sys_rst_n);
    end
    pll_lock = 1'b1;
    repeat (200) tick();
    pll_lock = 1'b0;
    repeat (10) tick();
    checks++;
    if (fault !== 1'b1 || pll_reset !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL fault_sticky: flt=%b rst=%b lk=%b, need 1 1 0", fault, pll_reset, locked);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear: flt=%b after reset_n, need 0", fault);
    end
    $display("fault: terminal state held, cleared by reset_n");
  endtask

  initial begin
    test_reset();
    test_lock_good();
    test_cfg_update();
    test_back_to_back();
    test_settle_lock_loss();
    test_async_reset();
    test_glitch();
    test_fault();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
